// File: rtl/div_pkg.sv
// Shared types and constants for the divider phase-strobe decoder.
package div_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 3;
  localparam int PERIOD    = 1 << CNT_W_DEF;
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/div_phase_counter.sv
// Free-running slot counter: counts 0..2**CNT_W-1 and wraps, async active-high reset.
module div_phase_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] lcnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lcnt <= '0;
    else     lcnt <= lcnt + 1'b1;
  end

endmodule

// File: rtl/div_phase_decoder.sv
// Phase-strobe receiver: recovers the strobe slot, tracks lock, flags missing/extra strobes.
// Optional saturating error counter is built when PHASE_STATS_EN is defined.
//
// state   | meaning
// SEARCH  | no candidate slot; next strobe becomes the candidate
// ACQUIRE | candidate held; counting consecutive strobes in that slot
// LOCKED  | phase_out valid; watching for missed and off-slot strobes
import div_pkg::*;

module div_phase_decoder #(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pulse_in,
  output logic [CNT_W-1:0]     phase_out,
  output logic                 locked,
  output logic                 err_miss,
  output logic                 err_extra
`ifdef PHASE_STATS_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);

  localparam logic [HIT_W-1:0]  HIT_ONE  = HIT_W'(1);
  localparam logic [HIT_W-1:0]  HIT_LOCK = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);
  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

  logic [CNT_W-1:0]  lcnt;
  logic [CNT_W-1:0]  cand;
  logic [HIT_W-1:0]  hit_cnt;
  logic [MISS_W-1:0] miss_cnt;
  state_t            state;
  logic              miss_evt;
  logic              extra_evt;

  div_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .lcnt (lcnt)
  );

  // Error events are decoded combinationally so the stats counter lands on the same edge.
  assign miss_evt  = (state == LOCKED) && (lcnt == phase_out) && !pulse_in;
  assign extra_evt = (state == LOCKED) && (lcnt != phase_out) &&  pulse_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      cand      <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      phase_out <= '0;
      locked    <= 1'b0;
      err_miss  <= 1'b0;
      err_extra <= 1'b0;
    end else begin
      err_miss  <= miss_evt;
      err_extra <= extra_evt;
      case (state)
        SEARCH: begin
          if (pulse_in) begin
            cand <= lcnt;
            if (LOCK_CNT == 1) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              phase_out <= lcnt;
              hit_cnt   <= '0;
              miss_cnt  <= '0;
            end else begin
              state   <= ACQUIRE;
              hit_cnt <= HIT_ONE;
            end
          end
        end
        ACQUIRE: begin
          if (lcnt == cand) begin
            if (pulse_in) begin
              if (hit_cnt + HIT_ONE == HIT_LOCK) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                phase_out <= cand;
                hit_cnt   <= '0;
                miss_cnt  <= '0;
              end else begin
                hit_cnt <= hit_cnt + HIT_ONE;
              end
            end else begin
              state   <= SEARCH;
              hit_cnt <= '0;
            end
          end else if (pulse_in) begin
            cand    <= lcnt;
            hit_cnt <= HIT_ONE;
          end
        end
        LOCKED: begin
          if (lcnt == phase_out) begin
            if (pulse_in) begin
              miss_cnt <= '0;
            end else if (miss_cnt + MISS_ONE == MISS_LIM) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              miss_cnt <= '0;
              hit_cnt  <= '0;
            end else begin
              miss_cnt <= miss_cnt + MISS_ONE;
            end
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHASE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if ((miss_evt || extra_evt) && (err_count != {ERR_CNT_W{1'b1}}))
      err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_div_phase_decoder.sv
// Scoreboard bench for div_phase_decoder: expected output changes are queued by the
// stimulus and matched by a monitor against every observed change of the outputs.
`timescale 1ns/1ps
module tb_div_phase_decoder;
  import div_pkg::*;

  typedef struct packed {
    logic       l;
    logic [2:0] p;
    logic       m;
    logic       x;
  } obs_t;

  typedef struct {
    int   edge_i;
    obs_t v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic [2:0] phase_out;
  logic       locked;
  logic       err_miss;
  logic       err_extra;
`ifdef PHASE_STATS_EN
  logic [7:0] err_count;
`endif

  int   errors = 0;
  int   checks = 0;
  int   edge_n = 0;
  bit   mon_en = 1'b1;
  exp_t exp_q[$];
  obs_t prev;
  obs_t cur;
  exp_t got_e;

  div_phase_decoder #(.CNT_W(3), .LOCK_CNT(4), .MISS_MAX(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .pulse_in  (pulse_in),
    .phase_out (phase_out),
    .locked    (locked),
    .err_miss  (err_miss),
    .err_extra (err_extra)
`ifdef PHASE_STATS_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Edge index since reset release; edge k samples slot (k-1) mod PERIOD.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    cur = {locked, phase_out, err_miss, err_extra};
    if (rst || !mon_en) begin
      prev = cur;
    end else if (cur !== prev) begin
      prev = cur;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change edge=%0d got l/p/m/x=%b/%0d/%b/%b", edge_n,
                 cur.l, cur.p, cur.m, cur.x);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.edge_i != edge_n || got_e.v !== cur) begin
          errors++;
          $display("FAIL output_change: got edge=%0d l/p/m/x=%b/%0d/%b/%b expected edge=%0d l/p/m/x=%b/%0d/%b/%b",
                   edge_n, cur.l, cur.p, cur.m, cur.x,
                   got_e.edge_i, got_e.v.l, got_e.v.p, got_e.v.m, got_e.v.x);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic tick(input logic p);
    pulse_in = p;
    @(negedge clk);
    pulse_in = 1'b0;
  endtask

  task automatic to_slot(input int s, output int e);
    while ((edge_n % PERIOD) != s) tick(1'b0);
    e = edge_n + 1;
  endtask

  task automatic expect_ev(input int e, input logic l, input int p, input logic m, input logic x);
    exp_t t;
    t.edge_i = e;
    t.v      = {l, 3'(p), m, x};
    exp_q.push_back(t);
  endtask

  task automatic strobe(input int s);
    int e;
    to_slot(s, e);
    tick(1'b1);
  endtask

  task automatic acquire(input int s);
    int e;
    repeat (3) strobe(s);
    to_slot(s, e);
    expect_ev(e, 1'b1, s, 1'b0, 1'b0);
    tick(1'b1);
  endtask

  task automatic miss(input int s, input logic drop);
    int e;
    to_slot(s, e);
    expect_ev(e,     !drop, s, 1'b1, 1'b0);
    expect_ev(e + 1, !drop, s, 1'b0, 1'b0);
    tick(1'b0);
  endtask

  task automatic extra(input int s, input int ph);
    int e;
    to_slot(s, e);
    expect_ev(e,     1'b1, ph, 1'b0, 1'b1);
    expect_ev(e + 1, 1'b1, ph, 1'b0, 1'b0);
    tick(1'b1);
  endtask

  initial begin
    int e;
    repeat (2) @(negedge clk);
    chk("reset_locked",    locked,    0);
    chk("reset_phase",     phase_out, 0);
    chk("reset_err_miss",  err_miss,  0);
    chk("reset_err_extra", err_extra, 0);
    rst = 1'b0;

    // Lock on slot 5, then single miss, double miss, re-lock.
    acquire(5);
    miss(5, 1'b0);
    strobe(5);
    miss(5, 1'b0);
    miss(5, 1'b1);
    acquire(5);

    // Off-slot strobe while locked.
    extra(2, 5);
    strobe(5);

    // Async reset in the middle of an err_extra pulse.
    to_slot(2, e);
    pulse_in = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_err_extra", err_extra, 1);
    chk("pre_rst_locked",    locked,    1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_locked",    locked,    0);
    chk("async_rst_phase",     phase_out, 0);
    chk("async_rst_err_extra", err_extra, 0);
    chk("async_rst_err_miss",  err_miss,  0);
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Candidate restart: two strobes at 3, then four at 6.
    strobe(3);
    strobe(3);
    acquire(6);

`ifdef PHASE_STATS_EN
    extra(1, 6);
    miss(6, 1'b0);
    strobe(6);
    miss(6, 1'b0);
    strobe(6);
    extra(1, 6);
    miss(6, 1'b0);
    strobe(6);
    chk("err_count_5", err_count, 5);
    mon_en   = 1'b0;
    pulse_in = 1'b1;
    repeat (360) @(negedge clk);
    pulse_in = 1'b0;
    @(negedge clk);
    chk("err_count_sat", err_count, 255);
`else
    repeat (2) @(negedge clk);
`endif

    chk("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
